// File: rtl/lab2_cmd_parser.sv
// Command parser sitting in front of the 4-bit ASCII adder.
// Recognises "<digit><op><digit>=" on the UART receive stream, launches the
// adder, captures its ASCII result (or an error character) and hands that byte
// to the UART transmitter over a valid/ready handshake.

module lab2_cmd_parser #(
    parameter int unsigned RDY_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       Gl_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [7:0] L2_adder_data,
    input  logic       L2_adder_rdy,
    output logic [7:0] Gl_r1,
    output logic [7:0] Gl_r2,
    output logic       Gl_subtract,
    output logic       Gl_adder_start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CntW = $clog2(RDY_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(RDY_TIMEOUT);

    localparam logic [7:0] ChSpace = 8'h20;
    localparam logic [7:0] ChPlus  = 8'h2B;
    localparam logic [7:0] ChMinus = 8'h2D;
    localparam logic [7:0] ChEq    = 8'h3D;
    localparam logic [7:0] ChBang  = 8'h21;
    localparam logic [7:0] ChQuery = 8'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StGotR1,
        StGotOp,
        StGotR2,
        StStart,
        StWaitRdy,
        StSend,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      r1_q, r1_d;
    logic [7:0]      r2_q, r2_d;
    logic            sub_q, sub_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;

    logic is_digit;
    logic is_space;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_space = (rx_data == ChSpace);
    assign cnt_inc  = cnt_q + 1'b1;

    // Next-state logic: parse bytes, launch the adder, capture result, drive tx.
    always_comb begin
        state_d    = state_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        sub_d      = sub_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && !is_space) begin
                    if (is_digit) begin
                        r1_d    = rx_data;
                        state_d = StGotR1;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StGotR1: begin
                if (rx_valid && !is_space) begin
                    if (rx_data == ChPlus) begin
                        sub_d   = 1'b0;
                        state_d = StGotOp;
                    end else if (rx_data == ChMinus) begin
                        sub_d   = 1'b1;
                        state_d = StGotOp;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StGotOp: begin
                if (rx_valid && !is_space) begin
                    if (is_digit) begin
                        r2_d    = rx_data;
                        state_d = StGotR2;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StGotR2: begin
                if (rx_valid && !is_space) begin
                    state_d = (rx_data == ChEq) ? StStart : StErr;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitRdy;
            end
            StWaitRdy: begin
                cnt_d = cnt_inc;
                // A result arriving on the timeout cycle still wins.
                if (L2_adder_rdy) begin
                    tx_data_d  = L2_adder_data;
                    tx_valid_d = 1'b1;
                    state_d    = StSend;
                end else if (cnt_inc == TimeoutVal) begin
                    tx_data_d  = ChBang;
                    tx_valid_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            StErr: begin
                tx_data_d  = ChQuery;
                tx_valid_d = 1'b1;
                state_d    = StSend;
            end
            default: state_d = StIdle;
        endcase

        // err is registered so it is high for exactly the ERR cycle.
        if (state_d == StErr) begin
            err_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Gl_rst_n) begin
            state_q    <= StIdle;
            r1_q       <= 8'h00;
            r2_q       <= 8'h00;
            sub_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            sub_q      <= sub_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Gl_r1          = r1_q;
    assign Gl_r2          = r2_q;
    assign Gl_subtract    = sub_q;
    assign Gl_adder_start = (state_q == StStart);
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign busy           = (state_q != StIdle);
    assign err            = err_q;

endmodule

// File: tb/tb_lab2_cmd_parser.sv
// Directed testbench for lab2_cmd_parser.

module tb_lab2_cmd_parser;

    logic       clk;
    logic       Gl_rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] L2_adder_data;
    logic       L2_adder_rdy;
    logic [7:0] Gl_r1;
    logic [7:0] Gl_r2;
    logic       Gl_subtract;
    logic       Gl_adder_start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;

    int total;
    int bad;
    int start_cnt;

    lab2_cmd_parser #(
        .RDY_TIMEOUT(32)
    ) dut (
        .clk           (clk),
        .Gl_rst_n      (Gl_rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .L2_adder_data (L2_adder_data),
        .L2_adder_rdy  (L2_adder_rdy),
        .Gl_r1         (Gl_r1),
        .Gl_r2         (Gl_r2),
        .Gl_subtract   (Gl_subtract),
        .Gl_adder_start(Gl_adder_start),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with the start pulse high, sampled at the active edge.
    always @(posedge clk) begin
        if (Gl_adder_start === 1'b1) start_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk8({tag, "_r1"}, Gl_r1, 8'h00);
        chk8({tag, "_r2"}, Gl_r2, 8'h00);
        chk1({tag, "_sub"}, Gl_subtract, 1'b0);
        chk1({tag, "_start"}, Gl_adder_start, 1'b0);
        chk8({tag, "_tx_data"}, tx_data, 8'h00);
        chk1({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    // Return the result with rdy in the first WAIT_RDY cycle, then handshake.
    task automatic finish_cmd(input string tag, input logic [7:0] res);
        step();
        chk1({tag, "_start_low"}, Gl_adder_start, 1'b0);
        L2_adder_data = res;
        L2_adder_rdy  = 1'b1;
        step();
        L2_adder_rdy  = 1'b0;
        chk1({tag, "_tx_valid"}, tx_valid, 1'b1);
        chk8({tag, "_tx_data"}, tx_data, res);
        chk1({tag, "_busy_send"}, busy, 1'b1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk1({tag, "_tx_valid_drop"}, tx_valid, 1'b0);
        chk1({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic test_reset();
        Gl_rst_n = 1'b0;
        step();
        step();
        Gl_rst_n = 1'b1;
        check_reset_values("reset");
    endtask

    task automatic test_add();
        int s0;
        s0 = start_cnt;
        send_byte(8'h33);
        send_byte(8'h2B);
        send_byte(8'h34);
        chk1("add_no_early_start", Gl_adder_start, 1'b0);
        send_byte(8'h3D);
        chk1("add_start", Gl_adder_start, 1'b1);
        chk8("add_r1", Gl_r1, 8'h33);
        chk8("add_r2", Gl_r2, 8'h34);
        chk1("add_sub", Gl_subtract, 1'b0);
        finish_cmd("add", 8'h37);
        chk8("add_start_count", 8'(start_cnt - s0), 8'd1);
    endtask

    task automatic test_sub_spaces();
        int s0;
        s0 = start_cnt;
        send_byte(8'h39);
        send_byte(8'h20);
        send_byte(8'h2D);
        send_byte(8'h32);
        send_byte(8'h3D);
        chk1("sub_start", Gl_adder_start, 1'b1);
        chk8("sub_r1", Gl_r1, 8'h39);
        chk8("sub_r2", Gl_r2, 8'h32);
        chk1("sub_sub", Gl_subtract, 1'b1);
        finish_cmd("sub", 8'h37);
        chk8("sub_start_count", 8'(start_cnt - s0), 8'd1);
    endtask

    task automatic test_parse_error();
        send_byte(8'h33);
        send_byte(8'h2A);
        chk1("perr_err", err, 1'b1);
        chk1("perr_busy", busy, 1'b1);
        step();
        chk1("perr_err_low", err, 1'b0);
        chk1("perr_tx_valid", tx_valid, 1'b1);
        chk8("perr_tx_data", tx_data, 8'h3F);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk1("perr_idle", busy, 1'b0);
        send_byte(8'h31);
        send_byte(8'h2B);
        send_byte(8'h31);
        send_byte(8'h3D);
        chk1("perr_recover_start", Gl_adder_start, 1'b1);
        chk8("perr_recover_r1", Gl_r1, 8'h31);
        chk1("perr_recover_sub", Gl_subtract, 1'b0);
        finish_cmd("perr_recover", 8'h32);
    endtask

    task automatic test_timeout();
        send_byte(8'h31);
        send_byte(8'h2B);
        send_byte(8'h31);
        send_byte(8'h3D);
        chk1("to_start", Gl_adder_start, 1'b1);
        step();
        // Now in the first WAIT_RDY cycle; 31 more edges keep it waiting.
        repeat (31) step();
        chk1("to_not_yet_valid", tx_valid, 1'b0);
        chk1("to_not_yet_err", err, 1'b0);
        step();
        chk1("to_err", err, 1'b1);
        chk1("to_tx_valid", tx_valid, 1'b1);
        chk8("to_tx_data", tx_data, 8'h21);
        L2_adder_data = 8'h55;
        L2_adder_rdy  = 1'b1;
        step();
        L2_adder_rdy  = 1'b0;
        chk1("to_err_low", err, 1'b0);
        chk8("to_late_rdy_ignored", tx_data, 8'h21);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk1("to_idle", busy, 1'b0);
    endtask

    task automatic test_back_to_back();
        int drift;
        drift = 0;
        send_byte(8'h35);
        send_byte(8'h2B);
        send_byte(8'h30);
        send_byte(8'h3D);
        step();
        L2_adder_data = 8'h35;
        L2_adder_rdy  = 1'b1;
        step();
        L2_adder_rdy  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_data  = 8'h37;
            rx_valid = 1'b1;
            if (tx_valid !== 1'b1 || tx_data !== 8'h35) drift++;
            step();
        end
        chk8("bp_hold_violations", 8'(drift), 8'd0);
        chk1("bp_still_valid", tx_valid, 1'b1);
        chk8("bp_r1_unchanged", Gl_r1, 8'h35);
        rx_data  = 8'h38;
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        chk1("bp_idle", busy, 1'b0);
        chk1("bp_tx_valid_low", tx_valid, 1'b0);
        chk8("bp_handshake_byte_dropped", Gl_r1, 8'h35);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h32);
        send_byte(8'h2D);
        send_byte(8'h32);
        send_byte(8'h3D);
        step();
        chk1("rst_mid_busy", busy, 1'b1);
        Gl_rst_n = 1'b0;
        step();
        Gl_rst_n = 1'b1;
        check_reset_values("rst_mid");
        L2_adder_data = 8'h30;
        L2_adder_rdy  = 1'b1;
        step();
        L2_adder_rdy  = 1'b0;
        chk1("rst_mid_late_rdy_valid", tx_valid, 1'b0);
        chk1("rst_mid_late_rdy_busy", busy, 1'b0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        start_cnt     = 0;
        Gl_rst_n      = 1'b0;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        L2_adder_data = 8'h00;
        L2_adder_rdy  = 1'b0;
        tx_ready      = 1'b0;

        test_reset();
        test_add();
        test_sub_spaces();
        test_parse_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab2_cmd_parser.md
Name: lab2_cmd_parser

Overview:
- Upstream command parser for the 4-bit ASCII adder stage.
- Consumes an ASCII byte stream from the UART receiver and recognises commands of the form `<digit><op><digit>=`.
- For each valid command it drives the adder's operand, subtract and start inputs, then waits for the adder's ready pulse.
- It captures the ASCII result and hands it to the UART transmitter through a valid/ready handshake.

Parameters:
- RDY_TIMEOUT, 32: cycles to wait in WAIT_RDY for L2_adder_rdy before aborting.

Ports:
- clk  input  1  global clock; all logic on posedge.
- Gl_rst_n  input  1  synchronous, active-low reset.
- rx_data  input  8  received ASCII byte; sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe, rx_data valid.
- L2_adder_data  input  8  ASCII result from the adder.
- L2_adder_rdy  input  1  adder result-ready pulse.
- Gl_r1  output  8  operand 1 ASCII byte to the adder.
- Gl_r2  output  8  operand 2 ASCII byte to the adder.
- Gl_subtract  output  1  1 = subtract, 0 = add.
- Gl_adder_start  output  1  one-cycle start pulse to the adder.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data valid; held until tx_ready.
- tx_ready  input  1  transmitter accepts the byte when tx_valid & tx_ready.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on a parse error or timeout.

Behaviour:
- Reset (Gl_rst_n=0 at posedge):
  - state=IDLE.
  - Gl_r1=Gl_r2=8'h00, Gl_subtract=0, Gl_adder_start=0.
  - tx_data=8'h00, tx_valid=0, err=0, timeout counter=0.
  - Reset in any state, including WAIT_RDY and SEND, aborts the command; any pending tx byte is dropped.
- Character classes:
  - digit = 8'h30–8'h39.
  - '+' = 8'h2B, '-' = 8'h2D, '=' = 8'h3D.
  - space 8'h20 is ignored (no state change) in IDLE, GOT_R1, GOT_OP and GOT_R2.
- States and transitions (all evaluated only on rx_valid=1 unless noted):
  - IDLE: digit → Gl_r1<=rx_data, go to GOT_R1. Any other non-space byte → ERR.
  - GOT_R1: '+' → Gl_subtract<=0; '-' → Gl_subtract<=1; either goes to GOT_OP. Other non-space byte → ERR.
  - GOT_OP: digit → Gl_r2<=rx_data, go to GOT_R2. Else → ERR.
  - GOT_R2: '=' → START. Else → ERR.
  - START (one cycle, unconditional): Gl_adder_start=1; clear counter; go to WAIT_RDY. The '=' accepted at edge t gives Gl_adder_start high during cycle t+1.
  - WAIT_RDY: counter increments each cycle.
    - L2_adder_rdy=1 → tx_data<=L2_adder_data, tx_valid<=1, go to SEND.
    - Otherwise, counter reaching RDY_TIMEOUT → tx_data<=8'h21 ('!'), err pulse, go to SEND.
    - rdy takes priority if it arrives in the same cycle as the timeout.
  - SEND: hold tx_valid and tx_data stable until tx_valid&tx_ready. On that edge tx_valid<=0 and go to IDLE.
  - ERR (one cycle): err=1; tx_data<=8'h3F ('?'), tx_valid<=1; go to SEND. Gl_r1, Gl_r2 and Gl_subtract keep their last values.
- Adder interface:
  - Gl_r1, Gl_r2 and Gl_subtract change only in parse states.
  - They are stable from START through the result capture.
- Ignored inputs:
  - rx_valid in START, WAIT_RDY, SEND and ERR is ignored and the byte is dropped. This includes a byte arriving in the same cycle as the tx handshake.
  - L2_adder_rdy outside WAIT_RDY is ignored.
- Gl_adder_start is never high for more than one cycle and never re-issued before returning to IDLE.

Test Plan:
- Add: bytes "3","+","4","=" → one Gl_adder_start pulse one cycle after "=" with Gl_r1=8'h33, Gl_r2=8'h34, Gl_subtract=0. Adder returns L2_adder_data=8'h37 with rdy → tx_valid=1, tx_data=8'h37. tx_ready=1 → back to IDLE, busy=0.
- Subtract with spaces: "9"," ","-","2","=" → Gl_r1=8'h39, Gl_r2=8'h32, Gl_subtract=1, start pulsed once. Return 8'h37 → tx_data=8'h37.
- Parse error: "3","*" → err pulse one cycle after "*", tx_data=8'h3F. After handshake, "1+1=" parses normally.
- Timeout: "1+1=" with L2_adder_rdy held 0 → after RDY_TIMEOUT (32) cycles in WAIT_RDY, err pulse and tx_data=8'h21. A rdy arriving later is ignored.
- Backpressure and drops: result 8'h35 with tx_ready=0 for 10 cycles → tx_valid and tx_data stay 1 / 8'h35 throughout. rx bytes during this time are dropped. On tx_ready=1 → IDLE.
- Reset mid-operation: Gl_rst_n=0 for one cycle in WAIT_RDY → next cycle all outputs equal their reset values and state=IDLE. A late L2_adder_rdy produces no tx_valid.
